// File: rtl/combo_tracker_pkg.sv
// Shared types and constants for the combo tracker: FSM encoding, combo limits
// and the saturating combo increment.
package combo_tracker_pkg;

   localparam int unsigned COMBO_W          = 4;
   localparam int unsigned RAMP_STEPS       = 16;
   localparam int unsigned FLASH_CYCLES_DEF = 64;

   localparam logic [COMBO_W-1:0] COMBO_MAX = 4'd15;

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } state_t;

   // Saturate check happens before the add so the 4-bit count never wraps.
   function automatic logic [COMBO_W-1:0] combo_inc(input logic [COMBO_W-1:0] c);
      return (c == COMBO_MAX) ? COMBO_MAX : c + COMBO_W'(1);
   endfunction

endpackage

// File: rtl/combo_tracker_edge_rise.sv
// Registered 1-bit rising-edge detector: pulse is high for the one cycle
// after d rises; a level held high yields a single pulse.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         prev  <= d;
         pulse <= d & ~prev;
      end
   end

endmodule

// File: rtl/combo_tracker.sv
// Consecutive-hit counter with best/lifetime tallies and a timed full-combo
// sweep that drives the LED bar decoder's 4-bit input.
module combo_tracker
   import combo_tracker_pkg::*;
#(
   parameter int unsigned FLASH_CYCLES = FLASH_CYCLES_DEF,  // multiple of 16, >= 16
   parameter int unsigned TOTAL_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hit_in,
   input  logic               miss_in,
   input  logic               clear,
   output logic [3:0]         combo,
   output logic [3:0]         max_combo,
   output logic [TOTAL_W-1:0] hit_total,
   output logic               flash_active,
   output logic [3:0]         display_combo
);

   localparam int unsigned FCW  = $clog2(FLASH_CYCLES);
   localparam int unsigned STEP = FLASH_CYCLES / RAMP_STEPS;
   localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_CYCLES - 1);

   logic hit_ev;
   logic miss_ev;

   state_t             state, state_n;
   logic [FCW-1:0]     flash_cnt, flash_cnt_n;
   logic [3:0]         combo_n, max_n, disp_n;
   logic [TOTAL_W-1:0] total_n;

   edge_rise u_hit_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (hit_in),
      .pulse (hit_ev)
   );

   edge_rise u_miss_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (miss_in),
      .pulse (miss_ev)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         flash_cnt     <= '0;
         combo         <= '0;
         max_combo     <= '0;
         hit_total     <= '0;
         display_combo <= '0;
      end else begin
         state         <= state_n;
         flash_cnt     <= flash_cnt_n;
         combo         <= combo_n;
         max_combo     <= max_n;
         hit_total     <= total_n;
         display_combo <= disp_n;
      end
   end

   assign flash_active = (state == FLASH);

   // Next-state logic; priority is clear, then miss, then hit
   always_comb begin
      state_n     = state;
      flash_cnt_n = flash_cnt;
      combo_n     = combo;
      max_n       = max_combo;
      total_n     = hit_total;

      if (state == FLASH) begin
         if (flash_cnt == FLASH_LAST) begin
            state_n     = IDLE;
            flash_cnt_n = '0;
         end else begin
            flash_cnt_n = flash_cnt + FCW'(1);
         end
      end

      if (clear) begin
         state_n     = IDLE;
         flash_cnt_n = '0;
         combo_n     = '0;
         max_n       = '0;
         total_n     = '0;
      end else if (miss_ev) begin
         state_n     = IDLE;
         flash_cnt_n = '0;
         combo_n     = '0;
      end else if (hit_ev) begin
         combo_n = combo_inc(combo);
         total_n = (hit_total == '1) ? hit_total : hit_total + TOTAL_W'(1);
         if (combo_n > max_combo) begin
            max_n = combo_n;
         end
         // Only the 14 -> 15 step launches the sweep
         if ((state == IDLE) && (combo == COMBO_MAX - 4'd1)) begin
            state_n     = FLASH;
            flash_cnt_n = '0;
         end
      end

      disp_n = (state_n == FLASH) ? COMBO_W'(flash_cnt_n / FCW'(STEP)) : combo_n;
   end

endmodule

// File: tb/tb_combo_tracker.sv
// Self-checking bench for combo_tracker: vector table plus hand sequences for
// full-combo sweep, abort, simultaneous edges, clear and async reset.
module tb_combo_tracker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hit_in;
   logic       miss_in;
   logic       clear;
   logic [3:0] combo;
   logic [3:0] max_combo;
   logic [7:0] hit_total;
   logic       flash_active;
   logic [3:0] display_combo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] combo;
      logic [3:0] max_c;
      logic [7:0] total;
      logic       flash;
      logic [3:0] disp;
   } exp_t;

   typedef struct {
      logic hit;
      logic miss;
      logic clr;
      exp_t e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   combo_tracker #(.FLASH_CYCLES(64), .TOTAL_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .hit_in        (hit_in),
      .miss_in       (miss_in),
      .clear         (clear),
      .combo         (combo),
      .max_combo     (max_combo),
      .hit_total     (hit_total),
      .flash_active  (flash_active),
      .display_combo (display_combo)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input int c, input int mx, input int t, input int f, input int d);
      exp_t e;
      e.combo = 4'(c);
      e.max_c = 4'(mx);
      e.total = 8'(t);
      e.flash = 1'(f);
      e.disp  = 4'(d);
      return e;
   endfunction

   function automatic vec_t mv(input logic h, input logic m, input logic c, input exp_t e);
      vec_t v;
      v.hit  = h;
      v.miss = m;
      v.clr  = c;
      v.e    = e;
      return v;
   endfunction

   task automatic chk(input string nm, input string field, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s.%s got %0d want %0d", nm, field, got, want);
      end
   endtask

   task automatic check_out(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty got 0 want 1", nm);
         return;
      end
      e = sb.pop_front();
      chk(nm, "combo",   int'(combo),         int'(e.combo));
      chk(nm, "max",     int'(max_combo),     int'(e.max_c));
      chk(nm, "total",   int'(hit_total),     int'(e.total));
      chk(nm, "flash",   int'(flash_active),  int'(e.flash));
      chk(nm, "display", int'(display_combo), int'(e.disp));
   endtask

   // Drive inputs, queue the expectation, clock once, compare after the edge
   task automatic cycle(input logic h, input logic m, input logic c, input exp_t e, input string nm);
      hit_in  = h;
      miss_in = m;
      clear   = c;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(nm);
   endtask

   task automatic do_clear(input string nm);
      cycle(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0), nm);
   endtask

   // n hit pulses from a cleared state; the 15th launches the sweep
   task automatic run_hits(input int n, input string nm);
      for (int i = 1; i <= n; i++) begin
         cycle(1'b1, 1'b0, 1'b0, mk(i-1, i-1, i-1, 0, i-1), nm);
         if (i == 15) cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 15, 1, 0), nm);
         else         cycle(1'b0, 1'b0, 1'b0, mk(i, i, i, 0, i), nm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout got 1 want 0");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n   = 1'b0;
      hit_in  = 1'b0;
      miss_in = 1'b0;
      clear   = 1'b0;
      #3;
      sb.push_back(mk(0, 0, 0, 0, 0));
      check_out("reset_state");
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // hit latency, 5 hits then miss, held level, simultaneous edges, clear
      vecs.push_back(mv(0, 0, 0, mk(0, 0, 0, 0, 0)));
      vecs.push_back(mv(1, 0, 0, mk(0, 0, 0, 0, 0)));
      vecs.push_back(mv(0, 0, 0, mk(1, 1, 1, 0, 1)));
      vecs.push_back(mv(1, 0, 0, mk(1, 1, 1, 0, 1)));
      vecs.push_back(mv(0, 0, 0, mk(2, 2, 2, 0, 2)));
      vecs.push_back(mv(1, 0, 0, mk(2, 2, 2, 0, 2)));
      vecs.push_back(mv(0, 0, 0, mk(3, 3, 3, 0, 3)));
      vecs.push_back(mv(1, 0, 0, mk(3, 3, 3, 0, 3)));
      vecs.push_back(mv(0, 0, 0, mk(4, 4, 4, 0, 4)));
      vecs.push_back(mv(1, 0, 0, mk(4, 4, 4, 0, 4)));
      vecs.push_back(mv(0, 0, 0, mk(5, 5, 5, 0, 5)));
      vecs.push_back(mv(0, 1, 0, mk(5, 5, 5, 0, 5)));
      vecs.push_back(mv(0, 0, 0, mk(0, 5, 5, 0, 0)));
      vecs.push_back(mv(1, 0, 0, mk(0, 5, 5, 0, 0)));
      for (int i = 0; i < 9; i++) vecs.push_back(mv(1, 0, 0, mk(1, 5, 6, 0, 1)));
      vecs.push_back(mv(0, 0, 0, mk(1, 5, 6, 0, 1)));
      vecs.push_back(mv(1, 1, 0, mk(1, 5, 6, 0, 1)));
      vecs.push_back(mv(0, 0, 0, mk(0, 5, 6, 0, 0)));
      vecs.push_back(mv(0, 0, 1, mk(0, 0, 0, 0, 0)));
      vecs.push_back(mv(0, 0, 0, mk(0, 0, 0, 0, 0)));
      foreach (vecs[i]) cycle(vecs[i].hit, vecs[i].miss, vecs[i].clr, vecs[i].e, $sformatf("vec%0d", i));

      // Full combo sweep, then two more hits with no new sweep
      do_clear("fc_clear");
      run_hits(15, "fc_hits");
      for (int k = 1; k < 64; k++) cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 15, 1, k / 4), $sformatf("fc_ramp%0d", k));
      cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 15, 0, 15), "fc_end");
      cycle(1'b1, 1'b0, 1'b0, mk(15, 15, 15, 0, 15), "fc_h16a");
      cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 16, 0, 15), "fc_h16b");
      cycle(1'b1, 1'b0, 1'b0, mk(15, 15, 16, 0, 15), "fc_h17a");
      cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 17, 0, 15), "fc_h17b");
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 17, 0, 15), "fc_noflash");

      // Miss lands on sweep cycle 20 and aborts it
      do_clear("ab_clear");
      run_hits(15, "ab_hits");
      for (int k = 1; k < 19; k++) cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 15, 1, k / 4), "ab_ramp");
      cycle(1'b0, 1'b1, 1'b0, mk(15, 15, 15, 1, 19 / 4), "ab_detect");
      cycle(1'b0, 1'b0, 1'b0, mk(0, 15, 15, 0, 0), "ab_abort");

      // Hit and miss rising together at combo 7
      do_clear("sim_clear");
      run_hits(7, "sim_hits");
      cycle(1'b1, 1'b1, 1'b0, mk(7, 7, 7, 0, 7), "sim_detect");
      cycle(1'b0, 1'b0, 1'b0, mk(0, 7, 7, 0, 0), "sim_result");

      // Clear with best combo 9
      do_clear("clr_clear");
      run_hits(9, "clr_hits");
      cycle(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0), "clr_result");

      // Asynchronous reset in the middle of a sweep
      do_clear("rst_clear");
      run_hits(15, "rst_hits");
      for (int k = 1; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, mk(15, 15, 15, 1, k / 4), "rst_ramp");
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(mk(0, 0, 0, 0, 0));
      check_out("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "rst_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
